// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared widths, grant encoding and slot type for the register-file write-back arbiter.
// Used by regfile_wb_arbiter and wb_rr_select.
package regfile_wb_arbiter_pkg;

    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 16;
    localparam int NUM_WB_REQ = 3;
    localparam logic [1:0] GRANT_NONE = 2'd3;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_DATA_W-1:0] data;
    } wb_slot_t;

    function automatic logic [1:0] wb_next_ptr(input logic [1:0] gid);
        return (gid == 2'd2) ? 2'd0 : gid + 2'd1;
    endfunction

    function automatic logic [1:0] wb_onehot_to_id(input logic [NUM_WB_REQ-1:0] oh);
        logic [1:0] id;
        id = GRANT_NONE;
        for (int i = 0; i < NUM_WB_REQ; i++) begin
            if (oh[i]) id = 2'(i);
        end
        return id;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_wb_rr_select.sv
// Grant selection: picks the first full slot starting at the priority pointer, one-hot out.
// A pointer value of 3 is never produced by the arbiter and is treated as 0.
module wb_rr_select
    import regfile_wb_arbiter_pkg::*;
(
    input  logic [NUM_WB_REQ-1:0] i_full,
    input  logic [1:0]            i_ptr,
    output logic [NUM_WB_REQ-1:0] o_grant
);

    always_comb begin
        logic [2:0] w_idx;
        logic       w_found;
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < NUM_WB_REQ; k++) begin
            w_idx = {1'b0, (i_ptr == 2'd3) ? 2'd0 : i_ptr} + 3'(k);
            if (w_idx >= 3'(NUM_WB_REQ)) w_idx = w_idx - 3'(NUM_WB_REQ);
            if (!w_found && i_full[w_idx[1:0]]) begin
                o_grant[w_idx[1:0]] = 1'b1;
                w_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Three-requester write-back arbiter feeding the register-file write port via one-entry slots.
// Define WB_FIXED_PRIO_EN for fixed priority 0 > 1 > 2 (no pointer register); default is round-robin.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_WB_REQ-1:0] reqValid,
    input  logic [REG_ADDR_W-1:0] reqAddr0,
    input  logic [REG_ADDR_W-1:0] reqAddr1,
    input  logic [REG_ADDR_W-1:0] reqAddr2,
    input  logic [REG_DATA_W-1:0] reqData0,
    input  logic [REG_DATA_W-1:0] reqData1,
    input  logic [REG_DATA_W-1:0] reqData2,
    output logic [NUM_WB_REQ-1:0] reqReady,
    output logic                  writeEnable,
    output logic [REG_ADDR_W-1:0] writeAddr,
    output logic [REG_DATA_W-1:0] writeData,
    output logic [1:0]            grantId
);

    wb_slot_t              r_slot [NUM_WB_REQ];
    logic [REG_ADDR_W-1:0] w_in_addr [NUM_WB_REQ];
    logic [REG_DATA_W-1:0] w_in_data [NUM_WB_REQ];
    logic [NUM_WB_REQ-1:0] w_full;
    logic [NUM_WB_REQ-1:0] w_grant;
    logic [1:0]            w_gid;
    logic [1:0]            w_ptr;
    wb_slot_t              w_sel;

    assign w_in_addr[0] = reqAddr0;
    assign w_in_addr[1] = reqAddr1;
    assign w_in_addr[2] = reqAddr2;
    assign w_in_data[0] = reqData0;
    assign w_in_data[1] = reqData1;
    assign w_in_data[2] = reqData2;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_WB_REQ; i++) begin
            w_full[i] = r_slot[i].valid;
            if (w_grant[i]) w_sel = r_slot[i];
        end
    end

    // Ready comes straight off the slot flops, so it never depends on reqValid.
    assign reqReady = ~w_full;
    assign w_gid    = wb_onehot_to_id(w_grant);

    wb_rr_select u_select (
        .i_full  (w_full),
        .i_ptr   (w_ptr),
        .o_grant (w_grant)
    );

`ifdef WB_FIXED_PRIO_EN
    assign w_ptr = 2'd0;
`else
    logic [1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= 2'd0;
        end else if (|w_grant) begin
            r_ptr <= wb_next_ptr(w_gid);
        end
    end

    assign w_ptr = r_ptr;
`endif

    // A granted slot is full, so it cannot also accept on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WB_REQ; i++) r_slot[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_WB_REQ; i++) begin
                if (w_grant[i]) begin
                    r_slot[i].valid <= 1'b0;
                end else if (reqValid[i] && !r_slot[i].valid) begin
                    r_slot[i] <= {1'b1, w_in_addr[i], w_in_data[i]};
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            writeEnable <= 1'b0;
            writeAddr   <= '0;
            writeData   <= '0;
            grantId     <= GRANT_NONE;
        end else if (|w_grant) begin
            writeEnable <= 1'b1;
            writeAddr   <= w_sel.addr;
            writeData   <= w_sel.data;
            grantId     <= w_gid;
        end else begin
            writeEnable <= 1'b0;
            grantId     <= GRANT_NONE;
        end
    end

endmodule

// File: doc/regfile_wb_arbiter.md
REGFILE_WB_ARBITER -- requirements
Module: regfile_wb_arbiter

Interface
REQ-001 The block SHALL have exactly one clock and a reset that is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 reqValid  input  3  per-requester write request; bit i belongs to requester i.
REQ-005 reqAddr0/1/2  input  3 each  destination register index of requester i.
REQ-006 reqData0/1/2  input  16 each  write data of requester i.
REQ-007 reqReady  output  3  bit i high means the slot for requester i is empty and will accept.
REQ-008 writeEnable  output  1  drives the register-file write-select decoder's enable.
REQ-009 writeAddr  output  3  drives the decoder select input.
REQ-010 writeData  output  16  data for the selected register.
REQ-011 grantId  output  2  index of the requester whose write is on the port; 2'd3 when idle.

Function
REQ-012 Each requester SHALL own one 1-entry holding slot (valid, addr, data).
REQ-013 A transfer SHALL occur on a rising edge when reqValid[i] and reqReady[i] are both high; the slot captures reqAddr_i/reqData_i.
REQ-014 reqReady[i] SHALL be registered and equal to NOT(slot i full); no combinational path from reqValid.
REQ-015 Each cycle the arbiter SHALL select one full slot, register it onto writeAddr/writeData/grantId, set writeEnable high for exactly that cycle, and empty the slot on the same edge.
REQ-016 Minimum latency SHALL be 2 edges: accept at edge E, writeEnable high in the cycle following edge E+1.
REQ-017 A slot emptied at edge E SHALL not accept new data at edge E; reqReady[i] rises after edge E (max 1 write per requester per 2 cycles).
REQ-018 With no full slot, writeEnable SHALL be 0, grantId 2'd3, and writeAddr/writeData SHALL hold their last values.
REQ-019 Default arbitration SHALL be round-robin: a 2-bit pointer names the highest-priority requester; after a grant to i the pointer SHALL move to (i+1) mod 3.
REQ-020 The pointer SHALL not change in cycles with no grant.
REQ-021 Two slots targeting the same writeAddr SHALL be issued in arbitration order on separate cycles; no merging or dropping.
REQ-022 A write to register index 0 SHALL be issued like any other index.
REQ-023 Holding a request while reqReady[i] is low SHALL have no effect; reqAddr/reqData may change freely until accepted.

Reset
REQ-024 While rst_n is low: all slots empty, reqReady = 3'b111 after reset, writeEnable = 0, writeAddr = 3'd0, writeData = 16'h0000, grantId = 2'd3, pointer = 2'd0.
REQ-025 Reset asserted mid-operation SHALL discard all pending slots and any write in flight; writeEnable SHALL drop asynchronously.
REQ-026 The first grant after reset release SHALL occur no earlier than the second rising edge after release.

Configuration
REQ-027 Macro WB_FIXED_PRIO_EN defined: fixed priority requester 0 > 1 > 2, pointer register omitted.
REQ-028 Macro WB_FIXED_PRIO_EN undefined: round-robin per REQ-019/REQ-020.
REQ-029 All other behaviour SHALL be identical in both builds.

Structure
REQ-030 A shared package SHALL hold REG_ADDR_W = 3, REG_DATA_W = 16, NUM_WB_REQ = 3, GRANT_NONE = 2'd3.
REQ-031 The grant-selection logic (full mask + pointer -> one-hot grant) SHALL be a sub-module named wb_rr_select; the slots and output registers stay in regfile_wb_arbiter.
REQ-032 writeEnable/writeAddr SHALL connect directly to the existing 3-to-8 write-select decoder without glue logic.

Verification
REQ-033 Single request: reqValid = 3'b010, addr 3'd5, data 16'hBEEF at edge 1 -> writeEnable high after edge 2 with writeAddr 5, writeData BEEF, grantId 1; reqReady[1] high again after edge 2.
REQ-034 Simultaneous requests: all three valid at edge 1 (addrs 1, 2, 3), pointer 0 -> grants 0, 1, 2 on three consecutive cycles, writeEnable high for 3 cycles, pointer ends at 0.
REQ-035 Round-robin fairness: requesters 0 and 2 held continuously valid -> grants alternate 0, 2, 0, 2; with WB_FIXED_PRIO_EN, requester 0 is granted whenever its slot is full.
REQ-036 Same-address conflict: requesters 0 and 1 both write addr 3'd7 (data 0x1111, 0x2222) -> two separate writes in pointer order, last writeData equals the later grant.
REQ-037 Reset mid-operation: two slots full, rst_n low for 1 cycle -> writeEnable 0 immediately, reqReady = 3'b111 after release, no stale write issued.
REQ-038 Idle hold: after a write of 16'hBEEF, no requests for 5 cycles -> writeEnable 0, grantId 3, writeData stays BEEF.
